// File: rtl/qq_host_ctrl.sv
// rtl/qq_host_ctrl.sv - host-side enq/deq initiator for the QuickQueue node chain
module qq_host_ctrl #(
    parameter int W      = 32,
    parameter int DEPTH  = 16,
    parameter int LAT    = 4,
    parameter int SETTLE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [W-1:0]               req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [W-1:0]               resp_data,
    output logic                       resp_err,
    output logic                       q_enq,
    output logic                       q_deq,
    output logic [W-1:0]               q_data_o,
    input  logic [W-1:0]               q_data_i,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int WMAX = (LAT > SETTLE) ? LAT : SETTLE;
    localparam int TW   = $clog2(WMAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          op_q;
    logic [TW-1:0] wait_cnt;

    // Occupancy flags follow count directly
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = (state == IDLE);

    // Request sequencing: accept, strobe the queue, wait out its latency, respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            wait_cnt   <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            q_enq      <= 1'b0;
            q_deq      <= 1'b0;
            q_data_o   <= '0;
        end else begin
            // strobes are single-cycle; only ISSUE entry raises them
            q_enq <= 1'b0;
            q_deq <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        if ((!req_op && full) || (req_op && empty)) begin
                            // reject locally; the queue never sees this request
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state    <= ISSUE;
                            q_data_o <= req_data;
                            q_enq    <= !req_op;
                            q_deq    <= req_op;
                        end
                    end
                end
                ISSUE: begin
                    if (op_q) begin
                        count    <= count - CW'(1);
                        wait_cnt <= TW'(LAT - 1);
                    end else begin
                        count    <= count + CW'(1);
                        wait_cnt <= TW'(SETTLE - 1);
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        // this edge closes the cycle in which dequeued data is valid
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= op_q ? q_data_i : '0;
                    end else begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qq_host_ctrl.sv
// tb/tb_qq_host_ctrl.sv - self-checking bench for qq_host_ctrl with a queue stub
module tb_qq_host_ctrl;

    localparam int W      = 32;
    localparam int DEPTH  = 16;
    localparam int LAT    = 4;
    localparam int SETTLE = 3;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_op;
    logic [W-1:0]  req_data;
    logic          resp_valid, resp_ready, resp_err;
    logic [W-1:0]  resp_data;
    logic          q_enq, q_deq;
    logic [W-1:0]  q_data_o;
    logic [W-1:0]  q_data_i = '0;
    logic [CW-1:0] count;
    logic          full, empty;

    int n_vec = 0;
    int n_err = 0;

    qq_host_ctrl #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .q_enq(q_enq), .q_deq(q_deq), .q_data_o(q_data_o), .q_data_i(q_data_i),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // queue stub: FIFO of enqueued words, dequeued word presented exactly LAT cycles after q_deq
    logic [W-1:0] stub_q[$];
    int           cyc    = 0;
    int           deq_at = -100;
    logic [W-1:0] deq_val = '0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        q_data_i = (cyc == deq_at + LAT) ? deq_val : 32'h0000_DEAD;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (q_enq) stub_q.push_back(q_data_o);
            if (q_deq) begin
                deq_at  = cyc;
                deq_val = (stub_q.size() > 0) ? stub_q.pop_front() : 32'hBAD0_BAD0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // one full request/response exchange; entered and left just after a rising edge
    task automatic txn(input logic op, input logic [W-1:0] d, input int rdy,
                       input logic e_err, input logic [W-1:0] e_data, input int e_cnt);
        int           lat;
        int           nenq;
        int           ndeq;
        int           sk;
        logic [W-1:0] sd;
        logic [W-1:0] hold;
        int           e_lat;
        bit           got;
        e_lat = e_err ? 1 : (op ? 2 + LAT : 2 + SETTLE);
        nenq = 0; ndeq = 0; sk = 0; sd = '0; got = 0;
        req_valid  = 1'b1;
        req_op     = op;
        req_data   = d;
        resp_ready = (rdy == 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        chk("req_accept", got, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        lat = 61;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (q_enq) begin nenq++; sk = k; sd = q_data_o; end
            if (q_deq) begin ndeq++; sk = k; end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("resp_latency", lat, e_lat);
        chk("resp_err", resp_err, e_err);
        chk("resp_data", resp_data, e_data);
        chk("enq_pulses", nenq, (!op && !e_err) ? 1 : 0);
        chk("deq_pulses", ndeq, (op && !e_err) ? 1 : 0);
        if (nenq + ndeq > 0) chk("strobe_cycle", sk, 1);
        if (nenq > 0) chk("q_data_o", sd, d);
        hold = resp_data;
        for (int i = 0; i < rdy; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, hold);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("count", count, e_cnt);
        chk("full", full, (e_cnt == DEPTH));
        chk("empty", empty, (e_cnt == 0));
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] d;
        int           rdy;
        logic         err;
        logic [W-1:0] data;
        int           cnt;
    } vec_t;

    vec_t         tbl[10];
    logic [W-1:0] mq[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0,         0,  1'b1, 32'h0,         0};
        tbl[1] = '{1'b0, 32'h5,         0,  1'b0, 32'h0,         1};
        tbl[2] = '{1'b1, 32'h0,         0,  1'b0, 32'h5,         0};
        tbl[3] = '{1'b0, 32'h1234_5678, 2,  1'b0, 32'h0,         1};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 0,  1'b0, 32'h0,         2};
        tbl[5] = '{1'b1, 32'h0,         10, 1'b0, 32'h1234_5678, 1};
        tbl[6] = '{1'b1, 32'h0,         0,  1'b0, 32'hFFFF_FFFF, 0};
        tbl[7] = '{1'b1, 32'h0,         1,  1'b1, 32'h0,         0};
        tbl[8] = '{1'b0, 32'h0,         0,  1'b0, 32'h0,         1};
        tbl[9] = '{1'b1, 32'h0,         0,  1'b0, 32'h0,         0};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_q_enq", q_enq, 0);
        chk("rst_q_deq", q_deq, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_q_data_o", q_data_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) txn(tbl[i].op, tbl[i].d, tbl[i].rdy, tbl[i].err, tbl[i].data, tbl[i].cnt);

        // fill to capacity, overflow is rejected, a following deq still works
        for (int i = 0; i < DEPTH; i++) txn(1'b0, W'(i + 1), 0, 1'b0, '0, i + 1);
        chk("full_after_fill", full, 1);
        txn(1'b0, 32'd17, 0, 1'b1, '0, DEPTH);
        txn(1'b1, '0, 0, 1'b0, 32'd1, DEPTH - 1);

        // asynchronous reset in the middle of a dequeue wait
        req_valid = 1'b1; req_op = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_q_deq", q_deq, 0);
        chk("arst_q_enq", q_enq, 0);
        chk("arst_q_data_o", q_data_o, 0);
        chk("arst_resp_data", resp_data, 0);
        chk("arst_resp_err", resp_err, 0);
        stub_q.delete();
        deq_at = -100;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rel_resp_valid", resp_valid, 0);
            chk("rel_count", count, 0);
            chk("rel_req_ready", req_ready, 1);
        end
        chk("rel_empty", empty, 1);
        @(posedge clk);
        #1;

        // randomized traffic against a plain FIFO model
        for (int n = 0; n < 200; n++) begin
            logic         op;
            logic [W-1:0] d;
            logic         e_err;
            logic [W-1:0] e_data;
            if (mq.size() == 0)          op = ($urandom_range(0, 3) == 0);
            else if (mq.size() == DEPTH) op = ($urandom_range(0, 3) != 0);
            else                         op = $urandom_range(0, 1);
            d      = $urandom;
            e_err  = op ? (mq.size() == 0) : (mq.size() == DEPTH);
            e_data = '0;
            if (!e_err) begin
                if (op) e_data = mq.pop_front();
                else    mq.push_back(d);
            end
            txn(op, d, $urandom_range(0, 3), e_err, e_data, mq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
